// File: rtl/core_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, control-flag
// bit positions and the decoded-instruction bundle carried through the buffer.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int CTRL_ISIMM        = 0;
    localparam int CTRL_ISALU        = 1;
    localparam int CTRL_ISBRANCH     = 2;
    localparam int CTRL_ISLOAD       = 3;
    localparam int CTRL_ISSTORE      = 4;
    localparam int CTRL_REG_AWVALID  = 5;
    localparam int CTRL_REG1_MEMREAD = 6;
    localparam int CTRL_REG2_MEMREAD = 7;
    localparam int CTRL_ISJAL        = 8;
    localparam int CTRL_ISJALR       = 9;
    localparam int CTRL_ISLUI        = 10;
    localparam int CTRL_ISAUIPC      = 11;
    localparam int CTRL_ISMUL        = 12;
    localparam int CTRL_W            = 13;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_e;

    typedef struct packed {
        logic [31:0]       imm;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        dec_t        dec;
    } entry_t;

endpackage

// File: rtl/core_idecode_comb.sv
// Purely combinational RV32I(+M) decoder producing one dec_t bundle per
// instruction; illegal encodings come out with ctrl and imm forced to zero.
module core_idecode_comb
    import core_pkg::*;
#(
    parameter bit M_EXT        = 1'b0,
    parameter bit RD0_SUPPRESS = 1'b1
) (
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path through it can infer a latch.
        ctrl    = '0;
        imm     = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                imm                     = imm_i;
                ctrl[CTRL_ISIMM]        = 1'b1;
                ctrl[CTRL_ISALU]        = 1'b1;
                ctrl[CTRL_REG_AWVALID]  = 1'b1;
                ctrl[CTRL_REG1_MEMREAD] = 1'b1;
                // Shift immediates reuse funct7 as an opcode extension.
                if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
            end
            OPC_OP: begin
                ctrl[CTRL_ISALU]        = 1'b1;
                ctrl[CTRL_REG_AWVALID]  = 1'b1;
                ctrl[CTRL_REG1_MEMREAD] = 1'b1;
                ctrl[CTRL_REG2_MEMREAD] = 1'b1;
                if (funct7 == F7_ALT) begin
                    illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
                end else if (funct7 == F7_MULDIV) begin
                    if (M_EXT) ctrl[CTRL_ISMUL] = 1'b1;
                    else       illegal = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                imm                     = imm_i;
                ctrl[CTRL_ISIMM]        = 1'b1;
                ctrl[CTRL_ISLOAD]       = 1'b1;
                ctrl[CTRL_REG_AWVALID]  = 1'b1;
                ctrl[CTRL_REG1_MEMREAD] = 1'b1;
                illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm                     = imm_s;
                ctrl[CTRL_ISIMM]        = 1'b1;
                ctrl[CTRL_ISSTORE]      = 1'b1;
                ctrl[CTRL_REG1_MEMREAD] = 1'b1;
                ctrl[CTRL_REG2_MEMREAD] = 1'b1;
                illegal = (funct3 >= 3'b011);
            end
            OPC_BRANCH: begin
                imm                     = imm_b;
                ctrl[CTRL_ISBRANCH]     = 1'b1;
                ctrl[CTRL_REG1_MEMREAD] = 1'b1;
                ctrl[CTRL_REG2_MEMREAD] = 1'b1;
                illegal = (funct3 == 3'b010 || funct3 == 3'b011);
            end
            OPC_JAL: begin
                imm                    = imm_j;
                ctrl[CTRL_ISJAL]       = 1'b1;
                ctrl[CTRL_REG_AWVALID] = 1'b1;
            end
            OPC_JALR: begin
                imm                     = imm_i;
                ctrl[CTRL_ISJALR]       = 1'b1;
                ctrl[CTRL_ISIMM]        = 1'b1;
                ctrl[CTRL_REG_AWVALID]  = 1'b1;
                ctrl[CTRL_REG1_MEMREAD] = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                imm                    = imm_u;
                ctrl[CTRL_ISLUI]       = 1'b1;
                ctrl[CTRL_ISIMM]       = 1'b1;
                ctrl[CTRL_REG_AWVALID] = 1'b1;
            end
            OPC_AUIPC: begin
                imm                    = imm_u;
                ctrl[CTRL_ISAUIPC]     = 1'b1;
                ctrl[CTRL_ISIMM]       = 1'b1;
                ctrl[CTRL_REG_AWVALID] = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (RD0_SUPPRESS && rd == 5'd0) ctrl[CTRL_REG_AWVALID] = 1'b0;
        if (illegal) begin
            ctrl = '0;
            imm  = '0;
        end
    end

    assign dec_o.imm     = imm;
    assign dec_o.funct3  = funct3;
    assign dec_o.funct7  = funct7;
    assign dec_o.rs1     = instr_i[19:15];
    assign dec_o.rs2     = instr_i[24:20];
    assign dec_o.rd      = rd;
    assign dec_o.ctrl    = ctrl;
    assign dec_o.illegal = illegal;

endmodule

// File: rtl/core_idecode_pipe.sv
// Decode stage: decodes on accept and queues the bundle in a DEPTH-entry FIFO
// with valid/ready handshakes on both sides, plus flush.
module core_idecode_pipe
    import core_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter bit          M_EXT        = 1'b0,
    parameter bit          RD0_SUPPRESS = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [31:0]                  IN_INSTR,
    input  logic [31:0]                  IN_PC,
    input  logic                         FLUSH,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [31:0]                  OUT_PC,
    output logic [31:0]                  OUT_IMM,
    output logic [2:0]                   OUT_FUNCT3,
    output logic [6:0]                   OUT_FUNCT7,
    output logic [4:0]                   OUT_RS1,
    output logic [4:0]                   OUT_RS2,
    output logic [4:0]                   OUT_RD,
    output logic [CTRL_W-1:0]            OUT_CTRL,
    output logic                         OUT_ILLEGAL,
    output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    entry_t           buf_q [DEPTH];
    entry_t           head;
    dec_t             dec;
    occ_state_e       occ_state;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    core_idecode_comb #(
        .M_EXT       (M_EXT),
        .RD0_SUPPRESS(RD0_SUPPRESS)
    ) u_decode (
        .instr_i(IN_INSTR),
        .dec_o  (dec)
    );

    always_comb begin
        if (count_q == '0)                  occ_state = OCC_EMPTY;
        else if (count_q == OCC_W'(DEPTH))  occ_state = OCC_FULL;
        else                                occ_state = OCC_PARTIAL;
    end

    // Ready comes from registered occupancy only, never from OUT_READY.
    assign IN_READY  = (occ_state != OCC_FULL);
    assign OUT_VALID = (occ_state != OCC_EMPTY);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      count_d = count_q + OCC_W'(1);
        else if (pop && !push) count_d = count_q - OCC_W'(1);
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; OUT_VALID qualifies it, so a reset would only cost flops.
    always_ff @(posedge CLK) begin
        if (push) buf_q[wr_ptr_q] <= '{pc: IN_PC, dec: dec};
    end

    assign head        = buf_q[rd_ptr_q];
    assign OUT_PC      = head.pc;
    assign OUT_IMM     = head.dec.imm;
    assign OUT_FUNCT3  = head.dec.funct3;
    assign OUT_FUNCT7  = head.dec.funct7;
    assign OUT_RS1     = head.dec.rs1;
    assign OUT_RS2     = head.dec.rs2;
    assign OUT_RD      = head.dec.rd;
    assign OUT_CTRL    = head.dec.ctrl;
    assign OUT_ILLEGAL = head.dec.illegal;
    assign OCCUPANCY   = count_q;

endmodule

// File: tb/tb_core_idecode_pipe.sv
// Directed bench: two decode stages (M_EXT=0 and M_EXT=1) share stimulus;
// expected bundles are queued on accept and compared when the head pops.
module tb_core_idecode_pipe;
    import core_pkg::*;

    localparam int DEPTH = 2;

    localparam logic [CTRL_W-1:0] K_IMM = CTRL_W'(1) << CTRL_ISIMM;
    localparam logic [CTRL_W-1:0] K_ALU = CTRL_W'(1) << CTRL_ISALU;
    localparam logic [CTRL_W-1:0] K_BR  = CTRL_W'(1) << CTRL_ISBRANCH;
    localparam logic [CTRL_W-1:0] K_LD  = CTRL_W'(1) << CTRL_ISLOAD;
    localparam logic [CTRL_W-1:0] K_ST  = CTRL_W'(1) << CTRL_ISSTORE;
    localparam logic [CTRL_W-1:0] K_AW  = CTRL_W'(1) << CTRL_REG_AWVALID;
    localparam logic [CTRL_W-1:0] K_R1  = CTRL_W'(1) << CTRL_REG1_MEMREAD;
    localparam logic [CTRL_W-1:0] K_R2  = CTRL_W'(1) << CTRL_REG2_MEMREAD;
    localparam logic [CTRL_W-1:0] K_JAL = CTRL_W'(1) << CTRL_ISJAL;
    localparam logic [CTRL_W-1:0] K_LUI = CTRL_W'(1) << CTRL_ISLUI;
    localparam logic [CTRL_W-1:0] K_MUL = CTRL_W'(1) << CTRL_ISMUL;

    logic        CLK = 1'b0;
    logic        RST, IN_VALID, FLUSH, OUT_READY;
    logic [31:0] IN_INSTR, IN_PC;

    logic              d0_in_ready, d0_out_valid, d0_ill, d1_in_ready, d1_out_valid, d1_ill;
    logic [31:0]       d0_pc, d0_imm, d1_pc, d1_imm;
    logic [2:0]        d0_f3, d1_f3;
    logic [6:0]        d0_f7, d1_f7;
    logic [4:0]        d0_rs1, d0_rs2, d0_rd, d1_rs1, d1_rs2, d1_rd;
    logic [CTRL_W-1:0] d0_ctrl, d1_ctrl;
    logic [1:0]        d0_occ, d1_occ;

    typedef struct {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [CTRL_W-1:0] ctrl0;
        logic              ill0;
        logic [CTRL_W-1:0] ctrl1;
        logic              ill1;
    } exp_t;

    exp_t sb[$];
    exp_t none;
    int   tests = 0;
    int   fails = 0;

    core_idecode_pipe #(.DEPTH(DEPTH), .M_EXT(1'b0), .RD0_SUPPRESS(1'b1)) dut0 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(d0_in_ready),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH),
        .OUT_VALID(d0_out_valid), .OUT_READY(OUT_READY), .OUT_PC(d0_pc), .OUT_IMM(d0_imm),
        .OUT_FUNCT3(d0_f3), .OUT_FUNCT7(d0_f7), .OUT_RS1(d0_rs1), .OUT_RS2(d0_rs2),
        .OUT_RD(d0_rd), .OUT_CTRL(d0_ctrl), .OUT_ILLEGAL(d0_ill), .OCCUPANCY(d0_occ)
    );

    core_idecode_pipe #(.DEPTH(DEPTH), .M_EXT(1'b1), .RD0_SUPPRESS(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(d1_in_ready),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH),
        .OUT_VALID(d1_out_valid), .OUT_READY(OUT_READY), .OUT_PC(d1_pc), .OUT_IMM(d1_imm),
        .OUT_FUNCT3(d1_f3), .OUT_FUNCT7(d1_f7), .OUT_RS1(d1_rs1), .OUT_RS2(d1_rs2),
        .OUT_RD(d1_rd), .OUT_CTRL(d1_ctrl), .OUT_ILLEGAL(d1_ill), .OCCUPANCY(d1_occ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [CTRL_W-1:0] ctrl0,
                                input logic ill0, input logic [CTRL_W-1:0] ctrl1, input logic ill1);
        exp_t e;
        e.instr = instr; e.pc = pc; e.imm = imm;
        e.ctrl0 = ctrl0; e.ill0 = ill0; e.ctrl1 = ctrl1; e.ill1 = ill1;
        return e;
    endfunction

    function automatic exp_t mk2(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [CTRL_W-1:0] ctrl, input logic ill);
        return mk(instr, pc, imm, ctrl, ill, ctrl, ill);
    endfunction

    // One clock: drive, check handshake state and any popped head, update the scoreboard.
    task automatic step(input logic v, input exp_t e, input logic rdy, input logic fl, input logic rs);
        exp_t h;
        IN_VALID = v; IN_INSTR = e.instr; IN_PC = e.pc;
        OUT_READY = rdy; FLUSH = fl; RST = rs;
        #1;
        check("occupancy", 32'(d0_occ), 32'(sb.size()));
        check("in_ready", 32'(d0_in_ready), 32'(sb.size() != DEPTH));
        check("out_valid", 32'(d0_out_valid), 32'(sb.size() != 0));
        check("m_in_ready", 32'(d1_in_ready), 32'(sb.size() != DEPTH));
        if (d0_out_valid && rdy && sb.size() != 0) begin
            h = sb.pop_front();
            check("out_pc", d0_pc, h.pc);
            check("out_imm", d0_imm, h.imm);
            check("out_rd", 32'(d0_rd), 32'(h.instr[11:7]));
            check("out_rs1", 32'(d0_rs1), 32'(h.instr[19:15]));
            check("out_rs2", 32'(d0_rs2), 32'(h.instr[24:20]));
            check("out_funct3", 32'(d0_f3), 32'(h.instr[14:12]));
            check("out_funct7", 32'(d0_f7), 32'(h.instr[31:25]));
            check("out_ctrl", 32'(d0_ctrl), 32'(h.ctrl0));
            check("out_illegal", 32'(d0_ill), 32'(h.ill0));
            check("m_out_pc", d1_pc, h.pc);
            check("m_out_imm", d1_imm, h.imm);
            check("m_out_ctrl", 32'(d1_ctrl), 32'(h.ctrl1));
            check("m_out_illegal", 32'(d1_ill), 32'(h.ill1));
        end
        if (fl || rs) sb.delete();
        else if (v && d0_in_ready) sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        none = mk2(32'h0, 32'h0, 32'h0, '0, 1'b0);
        RST = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
        IN_INSTR = '0; IN_PC = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);

        // Reset state, then single addi with one-cycle latency.
        step(1'b0, none, 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00500093, 32'h100, 32'd5, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b0, none, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream of formats and illegal encodings.
        step(1'b1, mk2(32'hFE208EE3, 32'h104, 32'hFFFFFFFC, K_BR | K_R1 | K_R2, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(32'h022081B3, 32'h108, 32'h0, '0, 1'b1,
                      K_ALU | K_MUL | K_AW | K_R1 | K_R2, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'hFF812283, 32'h10C, 32'hFFFFFFF8, K_IMM | K_LD | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h0060A623, 32'h110, 32'd12, K_IMM | K_ST | K_R1 | K_R2, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h123453B7, 32'h114, 32'h12345000, K_LUI | K_IMM | K_AW, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h008000EF, 32'h118, 32'd8, K_JAL | K_AW, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00003083, 32'h11C, 32'h0, '0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00000013, 32'h120, 32'h0, K_IMM | K_ALU | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'hFFFFFFFF, 32'h124, 32'h0, '0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h402081B3, 32'h128, 32'h0, K_ALU | K_AW | K_R1 | K_R2, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h40009093, 32'h12C, 32'h0, '0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h000090E7, 32'h130, 32'h0, '0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b0, none, 1'b1, 1'b0, 1'b0);

        // Fill to FULL with a stalled consumer, then overlap push and pop across the wrap.
        step(1'b1, mk2(32'h00100093, 32'h200, 32'd1, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00200113, 32'h204, 32'd2, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00300193, 32'h208, 32'd3, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00300193, 32'h208, 32'd3, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00300193, 32'h208, 32'd3, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00400213, 32'h20C, 32'd4, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'hFFF00293, 32'h210, 32'hFFFFFFFF, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b0, none, 1'b1, 1'b0, 1'b0);

        // FLUSH while FULL with input pending, then the same with RST.
        step(1'b1, mk2(32'h00100093, 32'h300, 32'd1, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00200113, 32'h304, 32'd2, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00300193, 32'h308, 32'd3, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b1, 1'b0);
        step(1'b0, none, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00100093, 32'h400, 32'd1, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00200113, 32'h404, 32'd2, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00300193, 32'h408, 32'd3, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b1);
        step(1'b0, none, 1'b0, 1'b0, 1'b0);

        // Same-cycle accept dropped by FLUSH and by RST mid-transfer.
        step(1'b1, mk2(32'h00500093, 32'h500, 32'd5, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00600093, 32'h504, 32'd6, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b1, 1'b0);
        step(1'b0, none, 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00700093, 32'h600, 32'd7, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00800093, 32'h604, 32'd8, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b1);
        step(1'b0, none, 1'b1, 1'b0, 1'b0);
        step(1'b1, mk2(32'h00900093, 32'h700, 32'd9, K_IMM | K_ALU | K_AW | K_R1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b0, none, 1'b1, 1'b0, 1'b0);
        step(1'b0, none, 1'b1, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
